// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : text_buffer_ctrl
//  Purpose  : Character-terminal front end for a text RAM. Bytes from a serial
//             receiver are buffered in a one-entry holding register and
//             interpreted as printable glyphs or control codes (BS, LF, CR,
//             FF). Printable bytes are written at the cursor. LF and FF start
//             blanking sweeps of one row or of the whole screen.
//  Ports    : clk      - system clock, rising edge
//             reset    - asynchronous reset, active low
//             rx_data  - received byte, qualified by rx_valid
//             rx_valid - single-cycle strobe for rx_data
//             wr_en    - text RAM write strobe, one cycle per cell
//             wr_row   - text RAM write row
//             wr_col   - text RAM write column
//             wr_data  - text RAM write data
//             cur_row  - cursor row
//             cur_col  - cursor column
//             busy     - high on every cycle that carries a sweep write
//             drop     - one-cycle pulse when a received byte is discarded
//  Revision : 1.0  initial release
// ============================================================================
module text_buffer_ctrl #(
   parameter int         COLS  = 32,
   parameter int         ROWS  = 4,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    wr_en,
   output logic [$clog2(ROWS)-1:0] wr_row,
   output logic [$clog2(COLS)-1:0] wr_col,
   output logic [7:0]              wr_data,
   output logic [$clog2(ROWS)-1:0] cur_row,
   output logic [$clog2(COLS)-1:0] cur_col,
   output logic                    busy,
   output logic                    drop
);

   localparam int c_ROW_W = $clog2(ROWS);
   localparam int c_COL_W = $clog2(COLS);
   // Row-major cell index used by the full-screen sweep: {row, col}.
   localparam int c_CNT_W = c_ROW_W + c_COL_W;

   // ROWS and COLS are powers of two, so the last index is all ones.
   localparam logic [c_COL_W-1:0] c_COL_MAX = '1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

   localparam logic [7:0] c_BS       = 8'h08;
   localparam logic [7:0] c_LF       = 8'h0A;
   localparam logic [7:0] c_FF       = 8'h0C;
   localparam logic [7:0] c_CR       = 8'h0D;
   localparam logic [7:0] c_PRINT_LO = 8'h20;
   localparam logic [7:0] c_PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLR_LINE = 2'd1,
      ST_CLR_ALL  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t               r_state;
   logic                 r_hold_full;
   logic [7:0]           r_hold_data;
   logic [c_ROW_W-1:0]   r_cur_row;
   logic [c_COL_W-1:0]   r_cur_col;
   logic                 r_wr_en;
   logic [c_ROW_W-1:0]   r_wr_row;
   logic [c_COL_W-1:0]   r_wr_col;
   logic [7:0]           r_wr_data;
   logic                 r_busy;
   logic                 r_drop;
   logic [c_CNT_W-1:0]   r_cnt;       // sweep position
   logic [c_ROW_W-1:0]   r_line_row;  // row being blanked by a line sweep

   // ------------------------------------------------------------------------
   // Next-state values
   // ------------------------------------------------------------------------
   state_t               w_state_nxt;
   logic                 w_hold_full_nxt;
   logic [7:0]           w_hold_data_nxt;
   logic [c_ROW_W-1:0]   w_cur_row_nxt;
   logic [c_COL_W-1:0]   w_cur_col_nxt;
   logic                 w_wr_en_nxt;
   logic [c_ROW_W-1:0]   w_wr_row_nxt;
   logic [c_COL_W-1:0]   w_wr_col_nxt;
   logic [7:0]           w_wr_data_nxt;
   logic                 w_busy_nxt;
   logic                 w_drop_nxt;
   logic [c_CNT_W-1:0]   w_cnt_nxt;
   logic [c_ROW_W-1:0]   w_line_row_nxt;
   logic                 w_consume;
   logic                 w_printable;

   assign w_printable = (r_hold_data >= c_PRINT_LO) && (r_hold_data <= c_PRINT_HI);

   // ------------------------------------------------------------------------
   // State register. Every output comes straight from a flop here, so a
   // cursor move and the write that goes with it land on the same edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_hold_full <= 1'b0;
         r_hold_data <= 8'h00;
         r_cur_row   <= '0;
         r_cur_col   <= '0;
         r_wr_en     <= 1'b0;
         r_wr_row    <= '0;
         r_wr_col    <= '0;
         r_wr_data   <= 8'h00;
         r_busy      <= 1'b0;
         r_drop      <= 1'b0;
         r_cnt       <= '0;
         r_line_row  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_hold_data <= w_hold_data_nxt;
         r_cur_row   <= w_cur_row_nxt;
         r_cur_col   <= w_cur_col_nxt;
         r_wr_en     <= w_wr_en_nxt;
         r_wr_row    <= w_wr_row_nxt;
         r_wr_col    <= w_wr_col_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_busy      <= w_busy_nxt;
         r_drop      <= w_drop_nxt;
         r_cnt       <= w_cnt_nxt;
         r_line_row  <= w_line_row_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_cur_row_nxt   = r_cur_row;
      w_cur_col_nxt   = r_cur_col;
      w_wr_en_nxt     = 1'b0;
      w_wr_row_nxt    = r_wr_row;
      w_wr_col_nxt    = r_wr_col;
      w_wr_data_nxt   = r_wr_data;
      w_busy_nxt      = 1'b0;
      w_cnt_nxt       = r_cnt;
      w_line_row_nxt  = r_line_row;
      w_consume       = 1'b0;
      w_hold_full_nxt = r_hold_full;
      w_hold_data_nxt = r_hold_data;
      w_drop_nxt      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_hold_full) begin
               w_consume = 1'b1;
               if (w_printable) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_row_nxt  = r_cur_row;
                  w_wr_col_nxt  = r_cur_col;
                  w_wr_data_nxt = r_hold_data;
                  // Column wraps to zero by natural overflow.
                  w_cur_col_nxt = r_cur_col + 1'b1;
                  if (r_cur_col == c_COL_MAX) begin
                     // Writing the last column behaves like a newline.
                     w_cur_row_nxt  = r_cur_row + 1'b1;
                     w_line_row_nxt = r_cur_row + 1'b1;
                     w_cnt_nxt      = '0;
                     w_state_nxt    = ST_CLR_LINE;
                  end
               end else begin
                  case (r_hold_data)
                     c_BS: begin
                        // Step back one cell in row-major order, stopping at
                        // the home position; the landing cell is blanked.
                        if (r_cur_col != '0) begin
                           w_cur_col_nxt = r_cur_col - 1'b1;
                        end else if (r_cur_row != '0) begin
                           w_cur_row_nxt = r_cur_row - 1'b1;
                           w_cur_col_nxt = c_COL_MAX;
                        end
                        w_wr_en_nxt   = 1'b1;
                        w_wr_row_nxt  = w_cur_row_nxt;
                        w_wr_col_nxt  = w_cur_col_nxt;
                        w_wr_data_nxt = BLANK;
                     end
                     c_LF: begin
                        w_cur_row_nxt  = r_cur_row + 1'b1;
                        w_line_row_nxt = r_cur_row + 1'b1;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = ST_CLR_LINE;
                     end
                     c_CR: begin
                        w_cur_col_nxt = '0;
                     end
                     c_FF: begin
                        w_cur_row_nxt = '0;
                        w_cur_col_nxt = '0;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_CLR_ALL;
                     end
                     default: begin
                        // Unsupported control code: swallowed silently.
                     end
                  endcase
               end
            end
         end

         ST_CLR_LINE: begin
            w_wr_en_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
            w_wr_row_nxt  = r_line_row;
            w_wr_col_nxt  = r_cnt[c_COL_W-1:0];
            w_wr_data_nxt = BLANK;
            w_cnt_nxt     = r_cnt + 1'b1;
            if (r_cnt[c_COL_W-1:0] == c_COL_MAX) begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_CLR_ALL: begin
            w_wr_en_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
            {w_wr_row_nxt, w_wr_col_nxt} = r_cnt;
            w_wr_data_nxt = BLANK;
            w_cnt_nxt     = r_cnt + 1'b1;
            if (r_cnt == c_CNT_MAX) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Holding register: a new byte may enter when the slot is empty or is
      // being emptied on this same edge; otherwise it is lost and flagged.
      if (rx_valid && (!r_hold_full || w_consume)) begin
         w_hold_full_nxt = 1'b1;
         w_hold_data_nxt = rx_data;
      end else if (w_consume) begin
         w_hold_full_nxt = 1'b0;
      end
      w_drop_nxt = rx_valid && r_hold_full && !w_consume;
   end

   assign wr_en   = r_wr_en;
   assign wr_row  = r_wr_row;
   assign wr_col  = r_wr_col;
   assign wr_data = r_wr_data;
   assign cur_row = r_cur_row;
   assign cur_col = r_cur_col;
   assign busy    = r_busy;
   assign drop    = r_drop;

endmodule
`default_nettype wire

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter COLS, default 32, meaning character columns per row (power of two).
REQ-002 The block SHALL have parameter ROWS, default 4, meaning character rows (power of two).
REQ-003 The block SHALL have parameter BLANK, default 8'h20, meaning the code written by erase operations.
REQ-004 The block SHALL have port clk  input  1  system clock (100 MHz); all logic is rising-edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port rx_data  input  8  received byte; valid only when rx_valid=1.
REQ-007 The block SHALL have port rx_valid  input  1  single-cycle strobe marking a new rx_data byte.
REQ-008 The block SHALL have port wr_en  output  1  text RAM write strobe, one cycle per cell.
REQ-009 The block SHALL have port wr_row  output  log2(ROWS)  text RAM write row.
REQ-010 The block SHALL have port wr_col  output  log2(COLS)  text RAM write column.
REQ-011 The block SHALL have port wr_data  output  8  text RAM write data.
REQ-012 The block SHALL have port cur_row  output  log2(ROWS)  current cursor row.
REQ-013 The block SHALL have port cur_col  output  log2(COLS)  current cursor column.
REQ-014 The block SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-015 The block SHALL have port drop  output  1  one-cycle pulse when a received byte is discarded.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The block SHALL hold one received byte in a one-entry holding register (hold_full flag).
REQ-018 A byte with rx_valid=1 SHALL load the holding register when hold_full=0, or when the FSM consumes the held byte on the same edge.
REQ-019 A byte with rx_valid=1 while hold_full=1 and no consume on that edge SHALL be discarded, with drop=1 on the next cycle.
REQ-020 The FSM SHALL have states IDLE, CLR_LINE and CLR_ALL.
REQ-021 In IDLE with hold_full=1, the FSM SHALL consume the held byte on the next edge.
REQ-022 Printable bytes 8'h20-8'h7E SHALL give a write of the byte at (cur_row, cur_col), then cur_col+1.
REQ-023 When a printable byte is written at cur_col=COLS-1, cur_col SHALL wrap to 0 and cur_row SHALL advance, with the same effect as LF (REQ-026).
REQ-024 Byte 8'h08 (BS) SHALL move the cursor back one cell and write BLANK there.
REQ-025 BS SHALL wrap from col 0 to col COLS-1 of the previous row; at (0,0), BS SHALL write BLANK at (0,0) and leave the cursor unchanged.
REQ-026 Byte 8'h0A (LF) SHALL set cur_row to (cur_row+1) mod ROWS, keep cur_col, and enter CLR_LINE on the new row.
REQ-027 Byte 8'h0D (CR) SHALL set cur_col=0, with no write.
REQ-028 Byte 8'h0C (FF) SHALL set the cursor to (0,0) and enter CLR_ALL.
REQ-029 All other bytes SHALL be consumed and ignored, with no write and no cursor change.
REQ-030 CLR_LINE SHALL issue COLS consecutive wr_en cycles writing BLANK at columns 0..COLS-1 of the target row, then return to IDLE.
REQ-031 CLR_ALL SHALL issue ROWS*COLS consecutive wr_en cycles writing BLANK in row-major order from (0,0) to (ROWS-1,COLS-1), then return to IDLE.
REQ-032 busy SHALL be 1 on exactly the cycles in which CLR_LINE or CLR_ALL writes are output.
REQ-033 Held bytes SHALL NOT be consumed while busy=1.
REQ-034 Latency: a printable byte sampled with rx_valid=1 at edge k, with hold_full=0 and FSM in IDLE, SHALL appear as wr_en=1 with its row, column and data at edge k+2.
REQ-035 A cursor update SHALL be visible in the same cycle as its associated wr_en.
REQ-036 wr_en SHALL be 0 in all cycles not specified above; wr_row, wr_col and wr_data are don't-care when wr_en=0.

Reset
REQ-037 While reset=0, the block SHALL force cur_row=0, cur_col=0, wr_en=0, wr_row=0, wr_col=0, wr_data=0, busy=0, drop=0, hold_full=0 and state IDLE, regardless of clk.
REQ-038 Reset asserted mid-sweep SHALL abort the sweep immediately, with no further wr_en.
REQ-039 After reset deasserts, the block SHALL resume at the first rising edge without performing an automatic screen clear.

Verification
REQ-040 The bench SHALL cover: reset, then bytes 'A' (8'h41) and 'B' -> writes (0,0,41) and (0,1,42), cursor (0,2), each write 2 cycles after its strobe.
REQ-041 The bench SHALL cover: 33 bytes 'x' from (0,0) -> writes at (0,0)..(0,31), then 32 BLANK writes on row 1, then 'x' at (1,0), with busy high for exactly 32 cycles.
REQ-042 The bench SHALL cover: cursor at (3,5), LF -> cursor (0,5), 32 BLANK writes on row 0; CR -> cursor (0,0), no write.
REQ-043 The bench SHALL cover: FF -> cursor (0,0) and 128 consecutive BLANK writes in row-major order; two more bytes strobed during the sweep -> the first is held and processed after the sweep, the second gives drop=1 once.
REQ-044 The bench SHALL cover: BS at (1,0) -> BLANK at (0,31) and cursor (0,31); BS at (0,0) -> BLANK at (0,0) and cursor unchanged.
REQ-045 The bench SHALL cover: reset=0 asserted at cycle 40 of a CLR_ALL sweep -> wr_en=0 and busy=0 immediately, with all outputs at their reset values.
